// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode digits through one shared decoder
// Ports: clk/rst_n (async active-low); enable starts/stops scanning; value_in+load give a packed nibble
// display value (digit 0 at [3:0]), committed at frame boundaries; lz_suppress blanks leading zeros.
// Outputs (all registered): bcd_out decoder nibble, digit_en_n active-low enables, digit_idx current
// digit, frame_done end-of-frame pulse, pending a loaded value awaits the next frame boundary.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic                          load,
  input  logic                          lz_suppress,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_en_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done,
  output logic                          pending
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int VW = 4*NUM_DIGITS;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] disp_q, disp_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] en_q, en_d, supp;
  logic [3:0] bcd_q, bcd_d;
  logic pend_q, pend_d, frame_q, frame_d;
  logic slot_end, last, wrap, lead;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    frame_d  = 1'b0;
    slot_end = cnt_q == CW'(SCAN_DIV-1);
    last     = idx_q == IW'(NUM_DIGITS-1);
    wrap     = state_q != IDLE && enable && slot_end && last;
    if (state_q == IDLE) begin
      if (enable) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
      idx_d   = slot_end ? (last ? '0 : idx_q + 1'b1) : idx_q;
      state_d = cnt_d < CW'(BLANK_CYCLES) ? BLANK : SHOW;
      frame_d = wrap;
    end
    // A load at the frame boundary (or while idle) bypasses the shadow entirely.
    if (load && (state_q == IDLE || wrap)) begin
      disp_d = value_in;
      pend_d = 1'b0;
    end else if (load) begin
      shadow_d = value_in;
      pend_d   = 1'b1;
    end else if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    // Leading-zero mask, scanned from the most significant digit downward.
    lead = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      lead    = lead & (disp_d[4*k +: 4] == 4'h0);
      supp[k] = lz_suppress && lead && k > 0;
    end
    en_d  = (state_d == SHOW && !supp[idx_d]) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    bcd_d = state_d == IDLE ? 4'h0 : disp_d[{idx_d, 2'b00} +: 4];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      frame_q  <= 1'b0;
      en_q     <= '1;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
      en_q     <= en_d;
      bcd_q    <= bcd_d;
    end
  end
  assign bcd_out    = bcd_q;
  assign digit_en_n = en_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_q;
  assign pending    = pend_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: frame-position reference model plus directed and random stimulus
module tb_seven_seg_scan_ctrl;
  localparam int N = 4, DIV = 8, BL = 2, FR = N*DIV;
  logic clk = 1'b0;
  logic rst_n, enable, load, lz_suppress;
  logic [15:0] value_in;
  logic [3:0] bcd_out, digit_en_n;
  logic [1:0] digit_idx;
  logic frame_done, pending;
  int errors = 0, checks = 0;
  logic [15:0] m_disp, m_shadow;
  logic m_pend, m_scan, m_fd, m_lz;
  int m_pos;
  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in), .load(load),
    .lz_suppress(lz_suppress), .bcd_out(bcd_out), .digit_en_n(digit_en_n),
    .digit_idx(digit_idx), .frame_done(frame_done), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  // Model: scanning is a position 0..FR-1 within the frame; the frame wraps at FR-1.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_disp = 0; m_shadow = 0; m_pend = 0; m_scan = 0; m_pos = 0; m_fd = 0; m_lz = 0;
    end else begin
      m_fd = 0;
      m_lz = lz_suppress;
      if (!m_scan) begin
        if (load) begin m_disp = value_in; m_pend = 0; end
        if (enable) begin m_scan = 1; m_pos = 0; end
      end else if (!enable) begin
        m_scan = 0;
        if (load) begin m_shadow = value_in; m_pend = 1; end
      end else if (m_pos == FR-1) begin
        m_pos = 0;
        m_fd = 1;
        if (load) begin m_disp = value_in; m_pend = 0; end
        else if (m_pend) begin m_disp = m_shadow; m_pend = 0; end
      end else begin
        m_pos++;
        if (load) begin m_shadow = value_in; m_pend = 1; end
      end
    end
  end
  initial forever begin
    int d;
    logic [3:0] e_en;
    logic sup;
    @(negedge clk);
    d = m_pos / DIV;
    sup = m_lz && d > 0 && (m_disp >> (4*d)) == 16'h0;
    e_en = (!m_scan || m_pos % DIV < BL || sup) ? 4'hF : ~(4'(1) << d);
    chk("m_en", 16'(digit_en_n), 16'(e_en));
    chk("m_idx", 16'(digit_idx), m_scan ? 16'(d) : 16'h0);
    chk("m_fd", 16'(frame_done), 16'(m_fd));
    chk("m_pend", 16'(pending), 16'(m_pend));
    if (m_scan) chk("m_bcd", 16'(bcd_out), 16'((m_disp >> (4*d)) & 16'hF));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_scan && m_pos == p) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_pos timeout pos=%0d", p);
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    value_in = v;
    load = 1;
    tick();
    load = 0;
  endtask
  initial begin
    rst_n = 1; enable = 0; load = 0; value_in = 0; lz_suppress = 0;
    #2 rst_n = 0;
    #5 rst_n = 1;
    #1;
    chk("rst_en", 16'(digit_en_n), 16'hF);
    chk("rst_bcd", 16'(bcd_out), 16'h0);
    chk("rst_idx", 16'(digit_idx), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_pend", 16'(pending), 16'h0);
    tick();
    do_load(16'h1234);
    chk("idle_pend", 16'(pending), 16'h0);
    enable = 1;
    tick();
    chk("t1_blank", 16'(digit_en_n), 16'hF);
    chk("t1_bcd_blank", 16'(bcd_out), 16'h4);
    wait_pos(2);  chk("t1_d0_en", 16'(digit_en_n), 16'hE); chk("t1_d0_bcd", 16'(bcd_out), 16'h4);
    wait_pos(7);  chk("t1_d0_last", 16'(digit_en_n), 16'hE);
    wait_pos(8);  chk("t1_d1_blank", 16'(digit_en_n), 16'hF);
    wait_pos(10); chk("t1_d1_en", 16'(digit_en_n), 16'hD); chk("t1_d1_bcd", 16'(bcd_out), 16'h3);
    wait_pos(18); chk("t1_d2_en", 16'(digit_en_n), 16'hB); chk("t1_d2_bcd", 16'(bcd_out), 16'h2);
    wait_pos(26); chk("t1_d3_en", 16'(digit_en_n), 16'h7); chk("t1_d3_bcd", 16'(bcd_out), 16'h1);
    chk("t1_d3_idx", 16'(digit_idx), 16'h3);
    wait_pos(31); chk("t1_fd_pre", 16'(frame_done), 16'h0);
    wait_pos(0);  chk("t1_fd", 16'(frame_done), 16'h1);
    wait_pos(4);  do_load(16'hABCD); chk("t2_pend", 16'(pending), 16'h1);
    wait_pos(10); chk("t2_old_d1", 16'(bcd_out), 16'h3);
    wait_pos(26); chk("t2_old_d3", 16'(bcd_out), 16'h1);
    wait_pos(0);  chk("t2_new_d0", 16'(bcd_out), 16'hD); chk("t2_pend_clr", 16'(pending), 16'h0);
    wait_pos(3);  do_load(16'h1111);
    wait_pos(12); do_load(16'h2222);
    wait_pos(2);  chk("t3_d0", 16'(bcd_out), 16'h2);
    wait_pos(26); chk("t3_d3", 16'(bcd_out), 16'h2);
    wait_pos(31); do_load(16'h5678);
    chk("t4_fd", 16'(frame_done), 16'h1);
    chk("t4_bcd", 16'(bcd_out), 16'h8);
    chk("t4_pend", 16'(pending), 16'h0);
    wait_pos(10); chk("t4_d1", 16'(bcd_out), 16'h7);
    lz_suppress = 1;
    wait_pos(5);  do_load(16'h0040);
    wait_pos(2);  chk("t5_d0_en", 16'(digit_en_n), 16'hE); chk("t5_d0_bcd", 16'(bcd_out), 16'h0);
    wait_pos(10); chk("t5_d1_en", 16'(digit_en_n), 16'hD); chk("t5_d1_bcd", 16'(bcd_out), 16'h4);
    wait_pos(18); chk("t5_d2_en", 16'(digit_en_n), 16'hF);
    wait_pos(26); chk("t5_d3_en", 16'(digit_en_n), 16'hF);
    wait_pos(5);  do_load(16'h0000);
    wait_pos(2);  chk("t5z_d0_en", 16'(digit_en_n), 16'hE);
    wait_pos(10); chk("t5z_d1_en", 16'(digit_en_n), 16'hF);
    lz_suppress = 0;
    wait_pos(20);
    enable = 0;
    tick();
    chk("t6_off_en", 16'(digit_en_n), 16'hF);
    chk("t6_off_idx", 16'(digit_idx), 16'h0);
    chk("t6_off_fd", 16'(frame_done), 16'h0);
    enable = 1;
    tick();
    wait_pos(18); do_load(16'h4321);
    wait_pos(20);
    chk("t6_pend_pre", 16'(pending), 16'h1);
    #1 rst_n = 0;
    #1;
    chk("t6_arst_en", 16'(digit_en_n), 16'hF);
    chk("t6_arst_bcd", 16'(bcd_out), 16'h0);
    chk("t6_arst_idx", 16'(digit_idx), 16'h0);
    chk("t6_arst_pend", 16'(pending), 16'h0);
    #1 rst_n = 1;
    tick();
    for (int i = 0; i < 4000; i++) begin
      enable = $urandom_range(0, 299) != 0;
      load = $urandom_range(0, 15) == 0;
      value_in = 16'($urandom) >> (4*$urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) lz_suppress = ~lz_suppress;
      tick();
    end
    load = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
